ika2151_dac_rx: RTL

// - Receiving end of the OPM serial audio link: deserializes SO using the SH1/SH2 latch strobes and phi1 clock enables.
// - Converts each 13-bit floating-point word (10-bit mantissa, 3-bit exponent) to signed linear PCM, as a YM3012 DAC does.
// - Sits beside the OPM core in the FPGA top level and feeds the audio mixer with left (SH1) and right (SH2) samples.

---
 rtl/ika2151_pkg.sv | 14 +
 rtl/ika2151_fp2lin.sv | 21 ++
 rtl/ika2151_dac_rx.sv | 114 +++++++++++
 3 files changed

// File: rtl/ika2151_pkg.sv
// rtl/ika2151_pkg.sv - shared constants and types for the OPM serial DAC receiver
package ika2151_pkg;

  localparam int EXP_W      = 3;
  localparam int MAN_W      = 10;
  localparam int FRAME_BITS = 16;
  localparam int PAD_BITS   = 3;

  typedef enum logic {
    WAIT_L,
    WAIT_R
  } pair_state_t;

endpackage

// File: rtl/ika2151_fp2lin.sv
// rtl/ika2151_fp2lin.sv - YM3012-style floating point (m,e) to signed 16-bit linear conversion
module ika2151_fp2lin
  import ika2151_pkg::*;
(
  input  logic [MAN_W-1:0] m,
  input  logic [EXP_W-1:0] e,
  output logic [15:0]      lin
);

  logic [MAN_W-1:0] s;
  logic [15:0]      s_ext;
  logic [EXP_W-1:0] sh;

  // The mantissa MSB is an inverted sign bit (offset binary to two's complement).
  assign s     = {~m[MAN_W-1], m[MAN_W-2:0]};
  assign s_ext = {{(16-MAN_W){s[MAN_W-1]}}, s};
  // e==0 is resolved by the parent; shifting by zero keeps this path well defined.
  assign sh    = (e == 3'd0) ? 3'd0 : (e - 3'd1);
  assign lin   = s_ext << sh;

endmodule

// File: rtl/ika2151_dac_rx.sv
// rtl/ika2151_dac_rx.sv - OPM serial audio link receiver producing left/right linear PCM samples
module ika2151_dac_rx
  import ika2151_pkg::*;
#(
  parameter int OUT_W    = 16,
  parameter bit ZERO_EXP = 1'b0
) (
  input  logic             i_EMUCLK,
  input  logic             i_IC_n,
  input  logic             i_phi1_NCEN_n,
  input  logic             i_SO,
  input  logic             i_SH1,
  input  logic             i_SH2,
  output logic [OUT_W-1:0] o_SAMPLE_L,
  output logic [OUT_W-1:0] o_SAMPLE_R,
  output logic             o_L_STB,
  output logic             o_R_STB,
  output logic             o_FRAME_STB
);

  generate
    if (OUT_W != 16) begin : g_bad_out_w
      $error("ika2151_dac_rx: OUT_W must be 16");
    end
  endgenerate

  logic                  enable;
  logic [FRAME_BITS-1:0] sr;
  logic [FRAME_BITS-1:0] word;
  logic                  sh1_z;
  logic                  sh2_z;
  logic                  fall1;
  logic                  fall2;
  logic [15:0]           lin;
  logic                  zero_e;
  logic                  hold_zero;
  pair_state_t           state_q;
  pair_state_t           state_d;
  logic                  frame_set;

  assign enable = ~i_phi1_NCEN_n;
  // The latched word includes the bit arriving on the same enable as the strobe edge.
  assign word   = {i_SO, sr[FRAME_BITS-1:1]};
  assign fall1  = enable & sh1_z & ~i_SH1;
  assign fall2  = enable & sh2_z & ~i_SH2;

  ika2151_fp2lin u_fp2lin (
    .m   (word[PAD_BITS +: MAN_W]),
    .e   (word[FRAME_BITS-1 -: EXP_W]),
    .lin (lin)
  );

  assign zero_e    = (word[FRAME_BITS-1 -: EXP_W] == 3'd0);
  assign hold_zero = zero_e & ZERO_EXP;

  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      sr          <= '0;
      sh1_z       <= 1'b1;
      sh2_z       <= 1'b1;
      o_SAMPLE_L  <= '0;
      o_SAMPLE_R  <= '0;
      o_L_STB     <= 1'b0;
      o_R_STB     <= 1'b0;
      o_FRAME_STB <= 1'b0;
    end else begin
      o_L_STB     <= fall1;
      o_R_STB     <= fall2;
      o_FRAME_STB <= frame_set;
      if (enable) begin
        sr    <= word;
        sh1_z <= i_SH1;
        sh2_z <= i_SH2;
      end
      if (fall1 && !hold_zero) begin
        o_SAMPLE_L <= zero_e ? '0 : lin;
      end
      if (fall2 && !hold_zero) begin
        o_SAMPLE_R <= zero_e ? '0 : lin;
      end
    end
  end

  always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
    if (!i_IC_n) begin
      state_q <= WAIT_L;
    end else begin
      state_q <= state_d;
    end
  end

  // A simultaneous L/R latch always counts as a complete pair.
  always_comb begin
    state_d   = state_q;
    frame_set = 1'b0;
    case (state_q)
      WAIT_L: begin
        if (fall1 && fall2) begin
          frame_set = 1'b1;
        end else if (fall1) begin
          state_d = WAIT_R;
        end
      end
      WAIT_R: begin
        if (fall2) begin
          state_d   = WAIT_L;
          frame_set = 1'b1;
        end
      end
      default: state_d = WAIT_L;
    endcase
  end

endmodule
